// File: rtl/silife_pkg.sv
// Shared definitions for the Life generation scheduler: default widths and
// the FSM state encoding that is also exported on the state port.
package silife_pkg;

    localparam int SILIFE_PERIOD_W = 16;
    localparam int SILIFE_GEN_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_STEP = 2'd3
    } gen_state_t;

endpackage

// File: rtl/silife_gen_sched.sv
// Generation scheduler: issues one-cycle step_en pulses to the cell matrix,
// either free-running every `period` cycles or as single steps, deferring while the bus is busy.
module silife_gen_sched
    import silife_pkg::*;
#(
    parameter int PERIOD_W = SILIFE_PERIOD_W,
    parameter int GEN_W    = SILIFE_GEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_run,
    input  logic                cmd_step,
    input  logic                cmd_clear,
    input  logic [PERIOD_W-1:0] period,
    input  logic [GEN_W-1:0]    gen_limit,
    input  logic                matrix_busy,
    output logic                step_en,
    output logic [GEN_W-1:0]    gen_count,
    output logic                running,
    output logic                done_irq,
    output logic [1:0]          state
);

    gen_state_t          state_reg, state_next;
    logic [PERIOD_W-1:0] timer_reg, timer_next;
    logic [GEN_W-1:0]    gen_count_reg, gen_count_next;
    logic                run_q_reg;
    logic                single_reg, single_next;
    logic                done_reg, done_next;

    logic                run_rise;
    logic                start_req;
    logic                limit_reached;
    logic                last_step;
    logic [PERIOD_W-1:0] period_eff;
    logic [GEN_W-1:0]    gen_inc;

    assign run_rise      = cmd_run & ~run_q_reg;
    assign start_req     = run_rise | cmd_step;
    assign period_eff    = (period == '0) ? PERIOD_W'(1) : period;
    assign gen_inc       = gen_count_reg + GEN_W'(1);
    assign limit_reached = (gen_limit != '0) && (gen_count_reg >= gen_limit);
    assign last_step     = (gen_limit != '0) && (gen_inc == gen_limit);

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        single_next    = single_reg;
        done_next      = 1'b0;
        gen_count_next = gen_count_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    if (limit_reached) begin
                        done_next = 1'b1;
                    end else begin
                        // A run edge wins over a coincident step request.
                        single_next = ~run_rise;
                        state_next  = matrix_busy ? ST_HOLD : ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                gen_count_next = gen_inc;
                if (single_reg || !cmd_run || last_step) begin
                    state_next = ST_IDLE;
                    done_next  = last_step;
                end else if (period_eff == PERIOD_W'(1)) begin
                    state_next = matrix_busy ? ST_HOLD : ST_STEP;
                end else begin
                    // STEP itself and the final timer==0 cycle account for two of P.
                    state_next = ST_WAIT;
                    timer_next = period_eff - PERIOD_W'(2);
                end
            end
            ST_WAIT: begin
                if (!cmd_run) begin
                    state_next = ST_IDLE;
                end else if (timer_reg == '0) begin
                    state_next = matrix_busy ? ST_HOLD : ST_STEP;
                end else begin
                    timer_next = timer_reg - PERIOD_W'(1);
                end
            end
            ST_HOLD: begin
                // A pending single step survives cmd_run being low.
                if (!single_reg && !cmd_run) begin
                    state_next = ST_IDLE;
                end else if (!matrix_busy) begin
                    state_next = ST_STEP;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (cmd_clear) begin
            gen_count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            gen_count_reg <= '0;
            run_q_reg     <= 1'b0;
            single_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            gen_count_reg <= gen_count_next;
            run_q_reg     <= cmd_run;
            single_reg    <= single_next;
            done_reg      <= done_next;
        end
    end

    assign step_en   = (state_reg == ST_STEP);
    assign running   = (state_reg != ST_IDLE);
    assign state     = state_reg;
    assign done_irq  = done_reg;
    assign gen_count = gen_count_reg;

endmodule

// File: tb/tb_silife_gen_sched.sv
// Scoreboard bench for silife_gen_sched: expected step/done cycles are queued
// as stimulus is driven and matched against pulses captured on the falling edge.
module tb_silife_gen_sched;

    localparam int PW = 16;
    localparam int GW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_run = 1'b0;
    logic          cmd_step = 1'b0;
    logic          cmd_clear = 1'b0;
    logic          matrix_busy = 1'b0;
    logic [PW-1:0] period = '0;
    logic [GW-1:0] gen_limit = '0;
    logic          step_en;
    logic [GW-1:0] gen_count;
    logic          running;
    logic          done_irq;
    logic [1:0]    state;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_steps[$];
    int act_steps[$];
    int exp_done[$];
    int act_done[$];

    silife_gen_sched #(.PERIOD_W(PW), .GEN_W(GW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_clear  (cmd_clear),
        .period     (period),
        .gen_limit  (gen_limit),
        .matrix_busy(matrix_busy),
        .step_en    (step_en),
        .gen_count  (gen_count),
        .running    (running),
        .done_irq   (done_irq),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_en)  act_steps.push_back(cyc);
        if (done_irq) act_done.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_pulse();
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++; if (state !== 2'd0)   begin n_err++; $display("FAIL reset_state: got %0d, expected 0", state); end
        n_cmp++; if (step_en !== 1'b0) begin n_err++; $display("FAIL reset_step_en: got %b, expected 0", step_en); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b, expected 0", running); end
        n_cmp++; if (done_irq !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, expected 0", done_irq); end
        n_cmp++; if (gen_count !== '0) begin n_err++; $display("FAIL reset_gen_count: got %0d, expected 0", gen_count); end
        reset = 1'b0;
        tick();
        act_steps.delete(); act_done.delete();
        $display("reset: checked");
    endtask

    task automatic test_free_run_p4();
        int c0, e, a;
        period = 16'd4; gen_limit = '0;
        cmd_run = 1'b1; c0 = cyc;
        for (int i = 0; i < 5; i++) exp_steps.push_back(c0 + 1 + 4 * i);
        wait_until(c0 + 17);
        cmd_run = 1'b0;
        repeat (6) tick();
        n_cmp++; if (act_steps.size() != exp_steps.size()) begin n_err++; $display("FAIL p4_count: got %0d steps, expected %0d", act_steps.size(), exp_steps.size()); end
        while (exp_steps.size() > 0 && act_steps.size() > 0) begin
            e = exp_steps.pop_front(); a = act_steps.pop_front(); n_cmp++;
            $display("p4 step: cycle %0d expected %0d", a, e);
            if (a !== e) begin n_err++; $display("FAIL p4_step: step at cycle %0d, expected %0d", a, e); end
        end
        n_cmp++; if (gen_count !== 32'd5) begin n_err++; $display("FAIL p4_gen_count: got %0d, expected 5", gen_count); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL p4_running: got %b, expected 0", running); end
        n_cmp++; if (act_done.size() != 0) begin n_err++; $display("FAIL p4_done: got %0d done pulses, expected 0", act_done.size()); end
        exp_steps.delete(); act_steps.delete(); act_done.delete();
    endtask

    task automatic test_period_one();
        int c0, e, a;
        clear_pulse();
        n_cmp++; if (gen_count !== '0) begin n_err++; $display("FAIL clear_idle: got %0d, expected 0", gen_count); end
        for (int p = 0; p < 2; p++) begin
            period = PW'(p);
            cmd_run = 1'b1; c0 = cyc;
            for (int i = 1; i <= 4; i++) exp_steps.push_back(c0 + i);
            wait_until(c0 + 4);
            cmd_run = 1'b0;
            repeat (4) tick();
            n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL p1_idle: period %0d state %0d, expected 0", p, state); end
        end
        n_cmp++; if (act_steps.size() != exp_steps.size()) begin n_err++; $display("FAIL p1_count: got %0d steps, expected %0d", act_steps.size(), exp_steps.size()); end
        while (exp_steps.size() > 0 && act_steps.size() > 0) begin
            e = exp_steps.pop_front(); a = act_steps.pop_front(); n_cmp++;
            $display("p1 step: cycle %0d expected %0d", a, e);
            if (a !== e) begin n_err++; $display("FAIL p1_step: step at cycle %0d, expected %0d", a, e); end
        end
        n_cmp++; if (gen_count !== 32'd8) begin n_err++; $display("FAIL p1_gen_count: got %0d, expected 8", gen_count); end
        exp_steps.delete(); act_steps.delete(); act_done.delete();
    endtask

    task automatic test_busy_hold();
        int c0, e, a;
        clear_pulse();
        period = 16'd3;
        cmd_run = 1'b1; c0 = cyc;
        exp_steps.push_back(c0 + 1);
        exp_steps.push_back(c0 + 9);
        exp_steps.push_back(c0 + 12);
        exp_steps.push_back(c0 + 15);
        wait_until(c0 + 2);
        matrix_busy = 1'b1;
        wait_until(c0 + 5);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL busy_hold_state: got %0d, expected 2", state); end
        wait_until(c0 + 8);
        matrix_busy = 1'b0;
        wait_until(c0 + 15);
        cmd_run = 1'b0;
        repeat (4) tick();
        n_cmp++; if (act_steps.size() != exp_steps.size()) begin n_err++; $display("FAIL busy_count: got %0d steps, expected %0d", act_steps.size(), exp_steps.size()); end
        while (exp_steps.size() > 0 && act_steps.size() > 0) begin
            e = exp_steps.pop_front(); a = act_steps.pop_front(); n_cmp++;
            $display("busy step: cycle %0d expected %0d", a, e);
            if (a !== e) begin n_err++; $display("FAIL busy_step: step at cycle %0d, expected %0d", a, e); end
        end
        n_cmp++; if (gen_count !== 32'd4) begin n_err++; $display("FAIL busy_gen_count: got %0d, expected 4", gen_count); end
        exp_steps.delete(); act_steps.delete(); act_done.delete();
    endtask

    task automatic test_limit();
        int c0, c1, e, a;
        clear_pulse();
        period = 16'd2; gen_limit = 32'd3;
        cmd_run = 1'b1; c0 = cyc;
        exp_steps.push_back(c0 + 1);
        exp_steps.push_back(c0 + 3);
        exp_steps.push_back(c0 + 5);
        exp_done.push_back(c0 + 6);
        wait_until(c0 + 12);
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL limit_running: got %b, expected 0", running); end
        cmd_run = 1'b0;
        tick();
        cmd_run = 1'b1; c1 = cyc;
        exp_done.push_back(c1 + 1);
        repeat (4) tick();
        cmd_run = 1'b0;
        n_cmp++; if (gen_count !== 32'd3) begin n_err++; $display("FAIL limit_gen_count: got %0d, expected 3", gen_count); end
        n_cmp++; if (act_steps.size() != exp_steps.size()) begin n_err++; $display("FAIL limit_count: got %0d steps, expected %0d", act_steps.size(), exp_steps.size()); end
        while (exp_steps.size() > 0 && act_steps.size() > 0) begin
            e = exp_steps.pop_front(); a = act_steps.pop_front(); n_cmp++;
            $display("limit step: cycle %0d expected %0d", a, e);
            if (a !== e) begin n_err++; $display("FAIL limit_step: step at cycle %0d, expected %0d", a, e); end
        end
        n_cmp++; if (act_done.size() != exp_done.size()) begin n_err++; $display("FAIL limit_done_count: got %0d pulses, expected %0d", act_done.size(), exp_done.size()); end
        while (exp_done.size() > 0 && act_done.size() > 0) begin
            e = exp_done.pop_front(); a = act_done.pop_front(); n_cmp++;
            $display("limit done: cycle %0d expected %0d", a, e);
            if (a !== e) begin n_err++; $display("FAIL limit_done: pulse at cycle %0d, expected %0d", a, e); end
        end
        gen_limit = '0;
        tick();
        exp_steps.delete(); act_steps.delete(); exp_done.delete(); act_done.delete();
    endtask

    task automatic test_single_step();
        int c0, c1, e, a;
        clear_pulse();
        cmd_step = 1'b1; matrix_busy = 1'b1; c0 = cyc;
        exp_steps.push_back(c0 + 3);
        tick();
        cmd_step = 1'b0;
        tick();
        matrix_busy = 1'b0;
        repeat (4) tick();
        n_cmp++; if (gen_count !== 32'd1) begin n_err++; $display("FAIL single_gen_count: got %0d, expected 1", gen_count); end
        period = 16'd4;
        cmd_run = 1'b1; c1 = cyc;
        exp_steps.push_back(c1 + 1);
        exp_steps.push_back(c1 + 5);
        exp_steps.push_back(c1 + 9);
        wait_until(c1 + 2);
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        wait_until(c1 + 9);
        cmd_run = 1'b0;
        repeat (4) tick();
        n_cmp++; if (act_steps.size() != exp_steps.size()) begin n_err++; $display("FAIL single_count: got %0d steps, expected %0d", act_steps.size(), exp_steps.size()); end
        while (exp_steps.size() > 0 && act_steps.size() > 0) begin
            e = exp_steps.pop_front(); a = act_steps.pop_front(); n_cmp++;
            $display("single step: cycle %0d expected %0d", a, e);
            if (a !== e) begin n_err++; $display("FAIL single_step: step at cycle %0d, expected %0d", a, e); end
        end
        n_cmp++; if (gen_count !== 32'd4) begin n_err++; $display("FAIL single_wait_gen_count: got %0d, expected 4", gen_count); end
        exp_steps.delete(); act_steps.delete(); act_done.delete();
    endtask

    task automatic test_clear_and_reset();
        int c0, r, e, a;
        clear_pulse();
        period = 16'd5;
        cmd_run = 1'b1; c0 = cyc;
        exp_steps.push_back(c0 + 1);
        exp_steps.push_back(c0 + 6);
        wait_until(c0 + 1);
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        n_cmp++; if (gen_count !== '0) begin n_err++; $display("FAIL clear_on_step: got %0d, expected 0", gen_count); end
        wait_until(c0 + 8);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL pre_reset_wait: got state %0d, expected 1", state); end
        n_cmp++; if (gen_count !== 32'd1) begin n_err++; $display("FAIL pre_reset_gen_count: got %0d, expected 1", gen_count); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (state !== 2'd0)   begin n_err++; $display("FAIL async_state: got %0d, expected 0", state); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL async_running: got %b, expected 0", running); end
        n_cmp++; if (step_en !== 1'b0) begin n_err++; $display("FAIL async_step_en: got %b, expected 0", step_en); end
        n_cmp++; if (gen_count !== '0) begin n_err++; $display("FAIL async_gen_count: got %0d, expected 0", gen_count); end
        repeat (3) tick();
        reset = 1'b0; r = cyc;
        exp_steps.push_back(r + 1);
        wait_until(r + 1);
        cmd_run = 1'b0;
        repeat (4) tick();
        n_cmp++; if (act_steps.size() != exp_steps.size()) begin n_err++; $display("FAIL rst_count: got %0d steps, expected %0d", act_steps.size(), exp_steps.size()); end
        while (exp_steps.size() > 0 && act_steps.size() > 0) begin
            e = exp_steps.pop_front(); a = act_steps.pop_front(); n_cmp++;
            $display("reset-run step: cycle %0d expected %0d", a, e);
            if (a !== e) begin n_err++; $display("FAIL rst_step: step at cycle %0d, expected %0d", a, e); end
        end
        n_cmp++; if (gen_count !== 32'd1) begin n_err++; $display("FAIL rst_gen_count: got %0d, expected 1", gen_count); end
        exp_steps.delete(); act_steps.delete(); act_done.delete();
    endtask

    initial begin
        test_reset();
        test_free_run_p4();
        test_period_one();
        test_busy_hold();
        test_limit();
        test_single_step();
        test_clear_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/silife_gen_sched.md
SILIFE_GEN_SCHED -- requirements
Module: silife_gen_sched

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16: width of generation-period field.
REQ-002 SHALL have parameter GEN_W, default 32: width of generation counter and limit.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_run  input  1  level; a rising edge starts free-run, low stops it.
REQ-006 SHALL have port cmd_step  input  1  one-cycle pulse requesting a single generation.
REQ-007 SHALL have port cmd_clear  input  1  one-cycle pulse zeroing gen_count.
REQ-008 SHALL have port period  input  PERIOD_W  cycles between generations; 0 treated as 1.
REQ-009 SHALL have port gen_limit  input  GEN_W  stop count; 0 = unlimited.
REQ-010 SHALL have port matrix_busy  input  1  wishbone matrix access in flight; steps deferred.
REQ-011 SHALL have port step_en  output  1  one-cycle enable to matrix, one generation per high cycle.
REQ-012 SHALL have port gen_count  output  GEN_W  generations executed.
REQ-013 SHALL have port running  output  1  high in any state except IDLE.
REQ-014 SHALL have port done_irq  output  1  one-cycle pulse when gen_count reaches gen_limit.
REQ-015 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-016 SHALL implement FSM IDLE=0, WAIT=1, HOLD=2, STEP=3; step_en = (state==STEP), registered-state decode only.
REQ-017 SHALL register cmd_run into run_q each cycle; run_rise = cmd_run & ~run_q.
REQ-018 IDLE: run_rise or cmd_step -> STEP if matrix_busy=0, else HOLD; run_rise has priority over cmd_step (both yield one entry).
REQ-019 IDLE: if gen_limit!=0 and gen_count>=gen_limit at run_rise/cmd_step -> stay IDLE, pulse done_irq next cycle, no step.
REQ-020 STEP: gen_count increments by 1 (wraps at 2^GEN_W-1 -> 0); effective period P = max(period,1) sampled this cycle.
REQ-021 STEP exit: if single-step, cmd_run=0, or gen_limit!=0 and gen_count+1==gen_limit -> IDLE; else P==1 -> step-due, else WAIT with timer=P-2.
REQ-022 WAIT: timer==0 -> step-due, else timer decrements; consecutive step_en pulses spaced exactly P cycles when matrix_busy stays low.
REQ-023 step-due: matrix_busy=0 -> STEP, else HOLD.
REQ-024 HOLD: remain while matrix_busy=1; -> STEP the cycle after matrix_busy samples 0; step_en never high in the cycle following a cycle with matrix_busy=1.
REQ-025 WAIT or HOLD with cmd_run=0 during free-run -> IDLE next cycle, no step; a pending single step in HOLD is not cancelled by cmd_run=0.
REQ-026 done_irq SHALL pulse the cycle after the STEP in which gen_count+1==gen_limit (gen_limit!=0), for free-run and single step alike.
REQ-027 cmd_clear SHALL zero gen_count next cycle; on coincidence with STEP, clear wins (result 0).
REQ-028 cmd_step outside IDLE SHALL be ignored; cmd_run held high after limit stop SHALL NOT restart without a new rising edge.
REQ-029 period/gen_limit changes SHALL take effect at the next STEP/limit comparison; no mid-interval reload.

Reset
REQ-030 reset SHALL asynchronously force state=IDLE, timer=0, gen_count=0, run_q=0, step_en=0, running=0, done_irq=0.
REQ-031 reset mid-WAIT/HOLD/STEP SHALL abort without a further step_en; first run after release needs a fresh cmd_run rising edge relative to run_q=0 (high cmd_run at release counts as an edge).

Structure
REQ-032 State encoding and PERIOD_W/GEN_W defaults SHALL live in shared package silife_pkg.
REQ-033 No sub-module; period timer and edge detect SHALL be inline, single always block for sequential state.

Verification
REQ-034 period=4, gen_limit=0, cmd_run rise -> step_en first high 1 cycle after edge, then every 4 cycles; 5 pulses -> gen_count=5.
REQ-035 period=0 and period=1 with run -> step_en high every cycle; drop cmd_run -> IDLE, no extra pulse.
REQ-036 period=3, matrix_busy high 6 cycles spanning a due step -> state=HOLD, step_en 1 cycle after busy falls, following spacing 3.
REQ-037 gen_limit=3, run -> exactly 3 step_en pulses, done_irq once, running=0 with cmd_run still high; new rise -> immediate done_irq, no step.
REQ-038 IDLE cmd_step with matrix_busy=1 for 2 cycles -> single step_en after busy low, gen_count+1; cmd_step during WAIT ignored.
REQ-039 cmd_clear coincident with STEP -> gen_count=0; reset asserted in WAIT -> all outputs 0 asynchronously, no step_en.
